sipo_deframer: RTL
==================

Name: sipo_deframer

Overview:
- Parametrised serial-in/parallel-out deserialiser; successor to the fixed 4-bit right-shift SIPO.
- Assembles WIDTH-bit words from a qualified serial stream, selectable LSB-first (right shift) or MSB-first (left shift).
- Presents each completed word on a holding register with a valid/ready handshake and a sticky overrun flag.
- Sits between a bit-serial receiver front end and word-oriented downstream logic.

Parameters:
- WIDTH, 8, word length in bits; legal range WIDTH >= 2.
- CNT_W, $clog2(WIDTH), localparam; width of the bit counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous flush; highest priority after reset.
- s_in  input  1  serial data bit.
- s_valid  input  1  s_in is sampled on this edge when high.
- msb_first  input  1  0 = LSB-first (right shift), 1 = MSB-first (left shift); latched per frame.
- p_ready  input  1  downstream accepts p_out this cycle.
- p_out  output  WIDTH  assembled word; stable while p_valid=1.
- p_valid  output  1  p_out holds an unconsumed word.
- bit_count  output  CNT_W  bits captured in the current partial frame.
- busy  output  1  high when bit_count != 0.
- overrun  output  1  sticky; a completed frame was dropped.

Behaviour:
- Reset (reset=0, async): shift register, p_out, p_valid, bit_count, overrun, mode latch all 0.
- Mode latch:
  - msb_first is sampled into mode_q on any edge with s_valid=1 and bit_count=0.
  - Changes to msb_first mid-frame are ignored until the next frame.
  - The first bit of a frame shifts using the new msb_first value directly.
- Shift, on each edge with s_valid=1 and clear=0:
  - LSB-first: sh <= {s_in, sh[WIDTH-1:1]}.
  - MSB-first: sh <= {sh[WIDTH-2:0], s_in}.
  - bit_count increments.
- s_valid=0: shift register and bit_count hold. Gaps between bits are allowed.
- Frame completion: an edge with s_valid=1 and bit_count=WIDTH-1.
  - bit_count wraps to 0.
  - The completed word is the shift result that includes the current bit.
- Word transfer at completion, on the same edge (one-edge latency from the last bit to p_valid=1):
  - If p_valid=0, or (p_valid=1 and p_ready=1): p_out <= completed word, p_valid <= 1.
  - If p_valid=1 and p_ready=0: word dropped, p_out and p_valid unchanged, overrun <= 1.
- Drain: p_valid=1 and p_ready=1 with no completion on that edge -> p_valid <= 0; p_out holds its last value.
- Simultaneous drain and completion: the new word replaces the old one, p_valid stays 1, no overrun.
- p_ready while p_valid=0 has no effect.
- clear=1 (synchronous):
  - Shift register, bit_count, mode_q, p_valid, overrun <= 0; p_out holds.
  - Overrides s_valid and p_ready on the same edge.
- overrun is cleared only by reset or clear.
- Reset asserted mid-frame discards the partial frame and any pending word.

Decomposition:
- Shared package:
  - Mode constants MODE_LSB_FIRST=1'b0, MODE_MSB_FIRST=1'b1.
  - Function clog2 helper for CNT_W.
- One sub-module, sipo_shift_core:
  - Contains the bidirectional WIDTH-bit shift register, bit counter, mode latch and a frame_done strobe.
  - The top level contains the holding register, handshake and overrun logic.

Test Plan:
1. LSB-first, WIDTH=8, msb_first=0, p_ready=1, bits in time order 1,0,1,1,0,0,1,0 -> p_out=8'h4D, p_valid high for exactly one cycle, bit_count returns to 0.
2. MSB-first, same bit sequence with msb_first=1 -> p_out=8'hB2. Toggling msb_first after bit 3 has no effect on the result.
3. Backpressure, p_ready=0: send frame 8'hA5 then frame 8'h3C (LSB-first) -> p_out stays 8'hA5, overrun=1 after the 3C frame's 8th bit; raise p_ready for one cycle -> p_valid=0.
4. Simultaneous: p_valid=1 holding 8'h11, p_ready=1 on the edge of the 8th bit of 8'h22 -> p_out=8'h22, p_valid stays 1, overrun=0.
5. Gaps and flush: 3 bits with idle cycles between them -> bit_count=3, busy=1; then clear=1 together with s_valid=1 -> bit_count=0, p_valid=0, overrun=0, and that bit is not captured.
6. Async reset mid-frame: after 5 bits with p_valid=1, drive reset=0 between clock edges -> all outputs 0 immediately. Release reset and send 8 bits -> a correct fresh word appears.

Source files
------------

// File: rtl/sipo_deframer_pkg.sv
// Shared definitions for the sipo_deframer serial-to-parallel block.
// Shift-order encodings and the counter width helper.
package sipo_deframer_pkg;

   localparam logic MODE_LSB_FIRST = 1'b0;
   localparam logic MODE_MSB_FIRST = 1'b1;

   function automatic int clog2(input int v);
      int r;
      int x;
      r = 0;
      x = v - 1;
      while (x > 0) begin
         r++;
         x = x >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// Bidirectional shift register, bit counter and per-frame mode latch.
// Presents the word including the current bit and strobes frame_done.
module sipo_shift_core
   import sipo_deframer_pkg::*;
#(
   parameter  int WIDTH = 8,
   localparam int CNT_W = clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             s_in,
   input  logic             s_valid,
   input  logic             msb_first,
   output logic [WIDTH-1:0] word,
   output logic [CNT_W-1:0] bit_count,
   output logic             frame_done
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   logic [WIDTH-1:0] sh;
   logic             mode_q;
   logic             mode_eff;
   logic             first_bit;

   // First bit of a frame uses the live pin, later bits the latched mode.
   always_comb begin
      first_bit  = 1'b0;
      mode_eff   = mode_q;
      word       = sh;
      frame_done = 1'b0;
      first_bit  = (bit_count == '0);
      if (first_bit) mode_eff = msb_first;
      if (mode_eff == MODE_MSB_FIRST) word = {sh[WIDTH-2:0], s_in};
      else                            word = {s_in, sh[WIDTH-1:1]};
      frame_done = s_valid && !clear && (bit_count == LAST);
   end

   // Shift state: flushed by clear, advanced by each qualified bit.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sh        <= '0;
         bit_count <= '0;
         mode_q    <= MODE_LSB_FIRST;
      end else if (clear) begin
         sh        <= '0;
         bit_count <= '0;
         mode_q    <= MODE_LSB_FIRST;
      end else if (s_valid) begin
         sh <= word;
         if (bit_count == LAST) bit_count <= '0;
         else                   bit_count <= bit_count + CNT_W'(1);
         if (first_bit) mode_q <= msb_first;
      end
   end

endmodule

// File: rtl/sipo_deframer.sv
// Serial-in/parallel-out deframer with valid/ready word output.
// Holds one word; a frame finishing while it is stalled sets overrun.
module sipo_deframer
   import sipo_deframer_pkg::*;
#(
   parameter  int WIDTH = 8,
   localparam int CNT_W = clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             s_in,
   input  logic             s_valid,
   input  logic             msb_first,
   input  logic             p_ready,
   output logic [WIDTH-1:0] p_out,
   output logic             p_valid,
   output logic [CNT_W-1:0] bit_count,
   output logic             busy,
   output logic             overrun
);

   logic [WIDTH-1:0] word;
   logic             frame_done;

   sipo_shift_core #(
      .WIDTH(WIDTH)
   ) u_core (
      .clk       (clk),
      .reset     (reset),
      .clear     (clear),
      .s_in      (s_in),
      .s_valid   (s_valid),
      .msb_first (msb_first),
      .word      (word),
      .bit_count (bit_count),
      .frame_done(frame_done)
   );

   assign busy = (bit_count != '0);

   // Holding register: load on completion if free or draining, else drop.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         p_out   <= '0;
         p_valid <= 1'b0;
         overrun <= 1'b0;
      end else if (clear) begin
         p_valid <= 1'b0;
         overrun <= 1'b0;
      end else if (frame_done) begin
         if (!p_valid || p_ready) begin
            p_out   <= word;
            p_valid <= 1'b1;
         end else begin
            overrun <= 1'b1;
         end
      end else if (p_valid && p_ready) begin
         p_valid <= 1'b0;
      end
   end

endmodule
